fft_peak_detector: RTL and testbench

- Downstream consumer of the FPGA top-level's serialized FFT output stream (output_re, output_im, index).
- Computes an approximate magnitude per bin and tracks the strongest bin in each 8-bin frame.
- Emits a per-frame peak report and a debounced tone-detected flag for status LEDs/UART logic.
- Sits between the FFT output serializer and the board-level reporting logic.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_peak_detector_if.sv | 30 +++
 rtl/fft_bin_mag.sv | 47 ++++
 rtl/fft_peak_detector.sv | 146 ++++++++++++++
 tb/tb_fft_peak_detector.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak detector slice.
// Widths, bin count, FSM state encoding, the sideband tag carried
// alongside each bin through the magnitude pipeline, and the
// abs / alpha-max-beta-min helper functions.
package fft_pkg;

  localparam int BIN_W = 16;
  localparam int MAG_W = 17;
  localparam int IDX_W = 3;
  localparam int NBINS = 8;
  localparam int ABS_W = BIN_W - 1;

  // Frame-alignment FSM encoding
  localparam logic [0:0] SYNC  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             first;  // opens a frame, reloads the tracker
    logic             last;   // closes a frame, triggers a report
  } bin_tag_t;

  // Absolute value; the single unrepresentable case (-2^15) saturates
  // so the result always fits in BIN_W-1 bits.
  function automatic logic [ABS_W-1:0] abs_sat(input logic signed [BIN_W-1:0] x);
    logic [BIN_W-1:0] n;
    if (x == {1'b1, {(BIN_W-1){1'b0}}}) return {ABS_W{1'b1}};
    n = x[BIN_W-1] ? (~x + BIN_W'(1)) : x;
    return n[ABS_W-1:0];
  endfunction

  // max + min/2; worst case 32767 + 16383 fits in MAG_W bits.
  function automatic logic [MAG_W-1:0] amb_mag(input logic [ABS_W-1:0] a,
                                               input logic [ABS_W-1:0] b);
    logic [ABS_W-1:0] mx, mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return {2'b00, mx} + {3'b000, mn[ABS_W-1:1]};
  endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// Bus between the FFT output serializer and the peak detector.
// master: source side (drives the bin stream, observes the report).
// slave : detector side (consumes bins, drives peak report / status).
//   in_valid, bin_re, bin_im, bin_index      : serialized FFT bins
//   peak_valid, peak_index, peak_mag         : per-frame peak report
//   detected, seq_err                        : debounced flag, order error pulse
interface fft_peak_detector_if;
  import fft_pkg::*;

  logic                    in_valid;
  logic signed [BIN_W-1:0] bin_re;
  logic signed [BIN_W-1:0] bin_im;
  logic [IDX_W-1:0]        bin_index;
  logic                    peak_valid;
  logic [IDX_W-1:0]        peak_index;
  logic [MAG_W-1:0]        peak_mag;
  logic                    detected;
  logic                    seq_err;

  modport master (
    output in_valid, bin_re, bin_im, bin_index,
    input  peak_valid, peak_index, peak_mag, detected, seq_err
  );

  modport slave (
    input  in_valid, bin_re, bin_im, bin_index,
    output peak_valid, peak_index, peak_mag, detected, seq_err
  );

endinterface

// File: rtl/fft_bin_mag.sv
// Two-stage magnitude pipeline for one FFT bin.
//   stage 1: saturating abs of re / im
//   stage 2: alpha-max-beta-min magnitude
// The bin tag (index, first/last) rides along unchanged.
// Ports: clk, rst (sync, active high), in_valid/re/im/tag_in in,
//        out_valid/mag/tag_out out (two cycles later).
module fft_bin_mag
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [BIN_W-1:0] re,
  input  logic signed [BIN_W-1:0] im,
  input  bin_tag_t                tag_in,
  output logic                    out_valid,
  output logic [MAG_W-1:0]        mag,
  output bin_tag_t                tag_out
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic [ABS_W-1:0] abs_re, abs_im;
  bin_tag_t         tag_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      abs_re   <= '0;
      abs_im   <= '0;
      tag_s1   <= '0;
      mag      <= '0;
      tag_out  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      abs_re   <= abs_sat(re);
      abs_im   <= abs_sat(im);
      tag_s1   <= tag_in;
      mag      <= amb_mag(abs_re, abs_im);
      tag_out  <= tag_s1;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak finder on the serialized FFT output stream.
// Aligns to 8-bin frames (SYNC/ACCUM), computes a magnitude per bin,
// tracks the strongest bin of each complete frame and debounces a
// tone-present flag over consecutive frames.
// Ports: clk, rst (sync, active high), bus (slave side of
//        fft_peak_detector_if: bin stream in, report/status out).
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESH        = 17'd4096,
  parameter int               DETECT_FRAMES = 3,
  parameter bit               IGNORE_DC     = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  fft_peak_detector_if.slave  bus
);

  localparam logic [3:0]       DF   = 4'(DETECT_FRAMES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBINS - 1);

  // ---------------- frame alignment FSM ----------------
  logic [0:0]       state, state_d;
  logic [IDX_W-1:0] nxt_idx, nxt_d;
  logic             accept, bad;
  bin_tag_t         tag_in;

  always_comb begin
    state_d      = state;
    nxt_d        = nxt_idx;
    accept       = 1'b0;
    bad          = 1'b0;
    tag_in       = '0;
    tag_in.idx   = bus.bin_index;
    if (bus.in_valid) begin
      bad = (state == ACCUM) && (bus.bin_index != nxt_idx);
      if (state == SYNC || bad) begin
        // An out-of-order 0 is a valid frame start on its own.
        if (bus.bin_index == '0) begin
          accept       = 1'b1;
          tag_in.first = 1'b1;
          state_d      = ACCUM;
          nxt_d        = IDX_W'(1);
        end else begin
          state_d = SYNC;
        end
      end else begin
        accept = 1'b1;
        nxt_d  = bus.bin_index + IDX_W'(1);
        if (bus.bin_index == LAST) begin
          tag_in.last = 1'b1;
          state_d     = SYNC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      nxt_idx     <= '0;
      bus.seq_err <= 1'b0;
    end else begin
      state       <= state_d;
      nxt_idx     <= nxt_d;
      bus.seq_err <= bad;
    end
  end

  // ---------------- magnitude pipeline ----------------
  logic             m_vld;
  logic [MAG_W-1:0] m_mag;
  bin_tag_t         m_tag;

  fft_bin_mag u_mag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .re        (bus.bin_re),
    .im        (bus.bin_im),
    .tag_in    (tag_in),
    .out_valid (m_vld),
    .mag       (m_mag),
    .tag_out   (m_tag)
  );

  // ---------------- peak tracker ----------------
  // A flushed frame never delivers its 'last' bin, and the next frame's
  // 'first' bin reloads the tracker, so no explicit flush is needed.
  logic [MAG_W-1:0] trk_mag, eff_mag, new_mag;
  logic [IDX_W-1:0] trk_idx, new_idx;
  logic             take;

  assign eff_mag = (IGNORE_DC && m_tag.idx == '0) ? '0 : m_mag;
  assign take    = m_tag.first || (eff_mag > trk_mag);  // strict: ties keep lower index
  assign new_mag = take ? eff_mag   : trk_mag;
  assign new_idx = take ? m_tag.idx : trk_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_mag        <= '0;
      trk_idx        <= '0;
      bus.peak_valid <= 1'b0;
      bus.peak_index <= '0;
      bus.peak_mag   <= '0;
    end else begin
      bus.peak_valid <= 1'b0;
      if (m_vld) begin
        trk_mag <= new_mag;
        trk_idx <= new_idx;
        if (m_tag.last) begin
          bus.peak_valid <= 1'b1;
          bus.peak_index <= new_idx;
          bus.peak_mag   <= new_mag;
        end
      end
    end
  end

  // ---------------- debounce ----------------
  logic [3:0] hit_cnt, miss_cnt, hit_nxt, miss_nxt;
  logic       hit;

  assign hit      = bus.peak_mag >= THRESH;
  assign hit_nxt  = (hit_cnt  >= DF) ? DF : hit_cnt  + 4'd1;
  assign miss_nxt = (miss_cnt >= DF) ? DF : miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      bus.detected <= 1'b0;
    end else if (bus.peak_valid) begin
      if (hit) begin
        hit_cnt  <= hit_nxt;
        miss_cnt <= '0;
        if (hit_nxt == DF) bus.detected <= 1'b1;
      end else begin
        miss_cnt <= miss_nxt;
        hit_cnt  <= '0;
        if (miss_nxt == DF) bus.detected <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed scoreboard bench for fft_peak_detector. Two instances see the
// same bin stream: dut (IGNORE_DC=1) and dut0 (IGNORE_DC=0).
module tb_fft_peak_detector;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_detector_if bus1 ();
  fft_peak_detector_if bus0 ();

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.bin_re    = bus1.bin_re;
  assign bus0.bin_im    = bus1.bin_im;
  assign bus0.bin_index = bus1.bin_index;

  fft_peak_detector #(.THRESH(17'd4096), .DETECT_FRAMES(3), .IGNORE_DC(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus1));
  fft_peak_detector #(.THRESH(17'd4096), .DETECT_FRAMES(3), .IGNORE_DC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic [2:0]  idx;
    logic [16:0] mag;
    logic        det;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int checks = 0;
  int passed = 0;
  int seq_cnt = 0;
  int seq_cyc_exp = -1;
  bit det_pend = 1'b0;
  bit det_exp = 1'b0;

  logic signed [15:0] fr_re[8];
  logic signed [15:0] fr_im[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (det_pend) begin
      chk("detected", int'(bus1.detected), int'(det_exp));
      det_pend = 1'b0;
    end
    if (bus1.peak_valid) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL unexpected report dut1: idx %0d mag %0d", bus1.peak_index, bus1.peak_mag);
      end else begin
        e = q1.pop_front();
        chk("dut1 peak_index", int'(bus1.peak_index), int'(e.idx));
        chk("dut1 peak_mag", int'(bus1.peak_mag), int'(e.mag));
        chk("dut1 report cycle", cyc, e.cyc);
        det_pend = 1'b1;
        det_exp  = e.det;
      end
    end
    if (bus0.peak_valid) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL unexpected report dut0: idx %0d mag %0d", bus0.peak_index, bus0.peak_mag);
      end else begin
        e = q0.pop_front();
        chk("dut0 peak_index", int'(bus0.peak_index), int'(e.idx));
        chk("dut0 peak_mag", int'(bus0.peak_mag), int'(e.mag));
      end
    end
    if (bus1.seq_err) begin
      seq_cnt++;
      chk("seq_err cycle", cyc, seq_cyc_exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bin(input logic [2:0] idx, input logic signed [15:0] re,
                           input logic signed [15:0] im);
    @(posedge clk); #1;
    bus1.in_valid  = 1'b1;
    bus1.bin_index = idx;
    bus1.bin_re    = re;
    bus1.bin_im    = im;
  endtask

  // Stall cycles carry junk that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus1.in_valid  = 1'b0;
      bus1.bin_index = 3'd5;
      bus1.bin_re    = 16'sd12345;
      bus1.bin_im    = -16'sd321;
    end
  endtask

  task automatic clr_frame();
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = '0;
      fr_im[b] = '0;
    end
  endtask

  task automatic send_frame(input bit stall, input logic [2:0] i1, input logic [16:0] m1,
                            input bit d1, input logic [2:0] i0, input logic [16:0] m0);
    exp_t e;
    for (int b = 0; b < 8; b++) begin
      drive_bin(3'(b), fr_re[b], fr_im[b]);
      if (b == 7) begin
        e.idx = i1; e.mag = m1; e.det = d1; e.cyc = cyc + 3;
        q1.push_back(e);
        e.idx = i0; e.mag = m0; e.det = 1'b0;
        q0.push_back(e);
      end else if (stall) begin
        idle(1);
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " peak_valid"}, int'(bus1.peak_valid), 0);
    chk({tag, " peak_index"}, int'(bus1.peak_index), 0);
    chk({tag, " peak_mag"},   int'(bus1.peak_mag), 0);
    chk({tag, " detected"},   int'(bus1.detected), 0);
    chk({tag, " seq_err"},    int'(bus1.seq_err), 0);
    chk({tag, " dut0 peak_mag"}, int'(bus0.peak_mag), 0);
  endtask

  initial begin
    bus1.in_valid  = 1'b0;
    bus1.bin_index = '0;
    bus1.bin_re    = '0;
    bus1.bin_im    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("initial reset");
    rst = 1'b0;
    idle(2);

    // Saturation: |-32768| -> 32767, mag 32767 + 16383
    clr_frame();
    fr_re[5] = -16'sd32768; fr_im[5] = -16'sd32768;
    send_frame(1'b0, 3'd5, 17'd49150, 1'b0, 3'd5, 17'd49150);
    idle(6);

    // Reset mid-frame: partial frame is discarded
    clr_frame();
    fr_re[1] = 16'sd30000;
    for (int b = 0; b < 5; b++) drive_bin(3'(b), fr_re[b], fr_im[b]);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("mid-frame reset");
    rst = 1'b0;
    clr_frame();
    fr_re[3] = 16'sd1000; fr_im[3] = -16'sd600;
    send_frame(1'b0, 3'd3, 17'd1300, 1'b0, 3'd3, 17'd1300);
    idle(6);

    // Tie and DC
    clr_frame();
    fr_re[0] = 16'sd30000; fr_re[2] = 16'sd2000; fr_re[6] = 16'sd2000;
    send_frame(1'b0, 3'd2, 17'd2000, 1'b0, 3'd0, 17'd30000);
    idle(6);

    // Sequence error: 0,1,2,5,6,7 then a clean frame
    drive_bin(3'd0, 16'sd0, 16'sd0);
    drive_bin(3'd1, 16'sd0, 16'sd0);
    drive_bin(3'd2, 16'sd20000, 16'sd0);
    drive_bin(3'd5, 16'sd0, 16'sd0);
    seq_cyc_exp = cyc + 1;
    drive_bin(3'd6, 16'sd0, 16'sd0);
    drive_bin(3'd7, 16'sd0, 16'sd0);
    clr_frame();
    fr_re[1] = 16'sd300; fr_im[1] = 16'sd400;
    send_frame(1'b0, 3'd1, 17'd550, 1'b0, 3'd1, 17'd550);
    idle(6);

    // Debounce: 3 hits set, 3 misses clear
    clr_frame();
    fr_re[4] = 16'sd5000;
    send_frame(1'b0, 3'd4, 17'd5000, 1'b0, 3'd4, 17'd5000);
    send_frame(1'b0, 3'd4, 17'd5000, 1'b0, 3'd4, 17'd5000);
    send_frame(1'b0, 3'd4, 17'd5000, 1'b1, 3'd4, 17'd5000);
    clr_frame();
    fr_re[6] = 16'sd100;
    send_frame(1'b0, 3'd6, 17'd100, 1'b1, 3'd6, 17'd100);
    send_frame(1'b0, 3'd6, 17'd100, 1'b1, 3'd6, 17'd100);
    send_frame(1'b0, 3'd6, 17'd100, 1'b0, 3'd6, 17'd100);
    idle(6);

    // Throughput: 4 back-to-back frames, then a stalled one
    clr_frame();
    fr_re[1] = -16'sd7000; fr_im[1] = 16'sd3000;
    send_frame(1'b0, 3'd1, 17'd8500, 1'b0, 3'd1, 17'd8500);
    clr_frame();
    fr_re[7] = 16'sd100; fr_im[7] = -16'sd32768;
    send_frame(1'b0, 3'd7, 17'd32817, 1'b0, 3'd7, 17'd32817);
    clr_frame();
    fr_re[3] = 16'sd6000; fr_im[3] = 16'sd6000; fr_re[5] = 16'sd9000;
    send_frame(1'b0, 3'd3, 17'd9000, 1'b1, 3'd3, 17'd9000);
    clr_frame();
    fr_re[2] = 16'sd4095;
    send_frame(1'b0, 3'd2, 17'd4095, 1'b1, 3'd2, 17'd4095);
    clr_frame();
    fr_im[6] = 16'sd4096;
    send_frame(1'b1, 3'd6, 17'd4096, 1'b1, 3'd6, 17'd4096);

    // Drain, bounded
    for (int t = 0; t < 40 && (q1.size() != 0 || q0.size() != 0); t++) idle(1);
    idle(3);
    chk("reports outstanding", q1.size() + q0.size(), 0);
    chk("seq_err pulses", seq_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
